// File: rtl/iram_pkg.sv
// Shared types for the 8051 internal data memory controller: op encodings, bank bases, FSM states.
package iram_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_RD_BYTE = 3'd1,
    OP_WR_BYTE = 3'd2,
    OP_RD_BIT  = 3'd3,
    OP_WR_BIT  = 3'd4,
    OP_SET_BIT = 3'd5,
    OP_CLR_BIT = 3'd6,
    OP_CPL_BIT = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RMW  = 2'd2
  } state_e;

  localparam logic [7:0]  BIT_BASE  = 8'h20;
  localparam logic [7:0]  SFR_BASE  = 8'h80;
  localparam int unsigned SFR_DEPTH = 128;

  // Apply a bit-level op to a byte; non-bit-write ops leave it unchanged.
  function automatic logic [7:0] bit_update(input logic [7:0] b, input logic [2:0] idx,
                                            input op_e op, input logic wbit);
    logic [7:0] r;
    r = b;
    case (op)
      OP_WR_BIT:  r[idx] = wbit;
      OP_SET_BIT: r[idx] = 1'b1;
      OP_CLR_BIT: r[idx] = 1'b0;
      OP_CPL_BIT: r[idx] = ~b[idx];
      default:    r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iram_bit_decode.sv
// Combinational address decode: bank select, byte index, bit index and out-of-range flag.
module iram_bit_decode
  import iram_pkg::*;
#(
  parameter int unsigned IRAM_DEPTH = 256,
  parameter bit          SFR_EN     = 1'b1
) (
  input  logic [7:0] addr_i,
  input  logic [2:0] op_i,
  input  logic       indirect_i,
  output logic       sel_sfr_o,
  output logic [7:0] byte_idx_o,
  output logic [2:0] bit_idx_o,
  output logic       oor_o
);

  op_e  op_c;
  logic is_bit_c;

  assign op_c     = op_e'(op_i);
  assign is_bit_c = (op_c >= OP_RD_BIT);

  always_comb begin
    sel_sfr_o  = 1'b0;
    byte_idx_o = addr_i;
    bit_idx_o  = addr_i[2:0];
    oor_o      = 1'b0;
    if (is_bit_c) begin
      if (!addr_i[7]) begin
        byte_idx_o = BIT_BASE + {4'b0000, addr_i[6:3]};
      end else begin
        // only 8-aligned SFR bytes are bit-addressable
        sel_sfr_o  = 1'b1;
        byte_idx_o = {addr_i[7:3], 3'b000} - SFR_BASE;
        oor_o      = !SFR_EN;
      end
    end else if (indirect_i) begin
      oor_o = (32'(addr_i) >= IRAM_DEPTH);
    end else if (addr_i[7]) begin
      sel_sfr_o  = 1'b1;
      byte_idx_o = addr_i - SFR_BASE;
      oor_o      = !SFR_EN;
    end
  end

endmodule

// File: rtl/iram_bitmem_ctrl.sv
// 8051 internal data memory controller: IRAM + SFR banks, byte/bit access, atomic bit RMW,
// valid/ready request port, registered response and clear-after-reset sequencer.
module iram_bitmem_ctrl
  import iram_pkg::*;
#(
  parameter int unsigned IRAM_DEPTH = 256,
  parameter bit          SFR_EN     = 1'b1,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [2:0] op_i,
  input  logic [7:0] addr_i,
  input  logic       indirect_i,
  input  logic [7:0] wdata_i,
  input  logic       wbit_i,
  output logic [7:0] rdata_o,
  output logic       rbit_o,
  output logic       rvalid_o,
  output logic       err_o
);

  localparam int unsigned IW        = $clog2(IRAM_DEPTH);
  localparam int unsigned INIT_CNT  = (IRAM_DEPTH > SFR_DEPTH) ? IRAM_DEPTH : SFR_DEPTH;
  localparam logic [7:0]  INIT_LAST = 8'(INIT_CNT - 1);
  localparam state_e      RST_STATE = INIT_CLEAR ? ST_INIT : ST_IDLE;

  logic [7:0] iram_q [IRAM_DEPTH];
  logic [7:0] sfr_q  [SFR_DEPTH];

  state_e     state_q;
  logic [7:0] init_cnt_q;
  logic       req_ready_q, rvalid_q, err_q, rbit_q;
  logic [7:0] rdata_q;
  logic       rmw_sfr_q;
  logic [7:0] rmw_idx_q;
  logic [2:0] rmw_bit_q;
  op_e        rmw_op_q;

  logic       dec_sfr, dec_oor;
  logic [7:0] dec_idx;
  logic [2:0] dec_bit;
  op_e        op_c;
  logic       accept_c;
  logic [7:0] rd_byte_c, rmw_old_c;
  logic       we_c, we_sfr_c;
  logic [7:0] we_idx_c, we_data_c;

  iram_bit_decode #(.IRAM_DEPTH(IRAM_DEPTH), .SFR_EN(SFR_EN)) u_decode (
    .addr_i     (addr_i),
    .op_i       (op_i),
    .indirect_i (indirect_i),
    .sel_sfr_o  (dec_sfr),
    .byte_idx_o (dec_idx),
    .bit_idx_o  (dec_bit),
    .oor_o      (dec_oor)
  );

  assign op_c      = op_e'(op_i);
  assign accept_c  = req_valid_i && req_ready_q && (state_q == ST_IDLE);
  assign rd_byte_c = dec_sfr ? sfr_q[dec_idx[6:0]] : iram_q[dec_idx[IW-1:0]];
  assign rmw_old_c = rmw_sfr_q ? sfr_q[rmw_idx_q[6:0]] : iram_q[rmw_idx_q[IW-1:0]];

  // Single write port shared by the RMW commit and accepted byte/bit writes.
  always_comb begin
    we_c      = 1'b0;
    we_sfr_c  = 1'b0;
    we_idx_c  = 8'h00;
    we_data_c = 8'h00;
    if (!reset_i) begin
      if (state_q == ST_RMW) begin
        we_c      = 1'b1;
        we_sfr_c  = rmw_sfr_q;
        we_idx_c  = rmw_idx_q;
        we_data_c = bit_update(rmw_old_c, rmw_bit_q, rmw_op_q, 1'b0);
      end else if (accept_c && !dec_oor && (op_c == OP_WR_BYTE)) begin
        we_c      = 1'b1;
        we_sfr_c  = dec_sfr;
        we_idx_c  = dec_idx;
        we_data_c = wdata_i;
      end else if (accept_c && !dec_oor && (op_c == OP_WR_BIT)) begin
        we_c      = 1'b1;
        we_sfr_c  = dec_sfr;
        we_idx_c  = dec_idx;
        we_data_c = bit_update(rd_byte_c, dec_bit, OP_WR_BIT, wbit_i);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i && (state_q == ST_INIT)) begin
      if (32'(init_cnt_q) < IRAM_DEPTH) iram_q[init_cnt_q[IW-1:0]] <= 8'h00;
      if (!init_cnt_q[7])               sfr_q[init_cnt_q[6:0]]     <= 8'h00;
    end else if (we_c) begin
      if (we_sfr_c) sfr_q[we_idx_c[6:0]]     <= we_data_c;
      else          iram_q[we_idx_c[IW-1:0]] <= we_data_c;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= RST_STATE;
      init_cnt_q  <= 8'h00;
      req_ready_q <= 1'b0;
      rdata_q     <= 8'h00;
      rbit_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rmw_sfr_q   <= 1'b0;
      rmw_idx_q   <= 8'h00;
      rmw_bit_q   <= 3'd0;
      rmw_op_q    <= OP_NOP;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 8'd1;
          if (init_cnt_q == INIT_LAST) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept_c && (op_c != OP_NOP)) begin
            rvalid_q <= 1'b1;
            if (dec_oor) begin
              err_q   <= 1'b1;
              rdata_q <= 8'h00;
              rbit_q  <= 1'b0;
            end else begin
              case (op_c)
                OP_RD_BYTE: rdata_q <= rd_byte_c;
                OP_RD_BIT:  rbit_q  <= rd_byte_c[dec_bit];
                OP_SET_BIT, OP_CLR_BIT, OP_CPL_BIT: begin
                  rvalid_q    <= 1'b0;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_RMW;
                  rmw_sfr_q   <= dec_sfr;
                  rmw_idx_q   <= dec_idx;
                  rmw_bit_q   <= dec_bit;
                  rmw_op_q    <= op_c;
                end
                default: ;
              endcase
            end
          end
        end
        ST_RMW: begin
          rvalid_q    <= 1'b1;
          rbit_q      <= rmw_old_c[rmw_bit_q];
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rdata_o     = rdata_q;
  assign rbit_o      = rbit_q;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;

endmodule
